// File: rtl/fetch_unit.sv
// Instruction-fetch controller: drives PC increments, reads a synchronous imem and queues {inst, pc} for decode.
// Defining FETCH_STATS_EN adds fetch_cnt/flush_cnt event counters; the default build omits them.
module fetch_unit #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 2,
  parameter int STEP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic          w_enable,
  output logic [AW-1:0] inc,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          br_taken,
  input  logic [AW-1:0] br_offset,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
`ifdef FETCH_STATS_EN
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   flush_cnt,
`endif
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  // Decode handshake: an entry moves when inst_valid && inst_ready at a rising
  // edge; inst/inst_pc hold while inst_valid && !inst_ready.

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];

  logic pop;
  logic push;
  logic flush;
  logic space;

  assign imem_addr  = pc;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? data_mem_q[rptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[rptr_q] : '0;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight_q & ~flush;
  // Pop never exceeds count, so this cannot underflow; CW bits hold DEPTH+1.
  assign space      = (count_q + CW'(inflight_q) - CW'(pop)) < CW'(DEPTH);
  assign dbg_state  = state_q;

  always_comb begin
    state_d  = state_q;
    w_enable = 1'b0;
    inc      = '0;
    imem_rd  = 1'b0;
    flush    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (br_taken) begin
          w_enable = 1'b1;
          inc      = br_offset;
          flush    = 1'b1;
          state_d  = S_REDIR;
        end else if (space) begin
          w_enable = 1'b1;
          inc      = AW'(STEP);
          imem_rd  = 1'b1;
        end
      end
      S_REDIR: begin
        state_d = S_RUN;
        if (br_taken) begin
          w_enable = 1'b1;
          inc      = br_offset;
          flush    = 1'b1;
          state_d  = S_REDIR;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    inflight_d = imem_rd;
    tag_d      = imem_rd ? pc : tag_q;
    if (flush) begin
      // A redirect discards queued entries, the arriving response and any pop.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem_q[wptr_q] <= imem_data;
      pc_mem_q[wptr_q]   <= tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(pop && count_q == '0))
        else $error("fetch_unit: pop from empty queue");
      assert (!(push && !pop && count_q == CW'(DEPTH)))
        else $error("fetch_unit: push to full queue");
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (imem_rd) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (flush)   flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and synchronous imem environment, directed timing phases, random traffic.
module tb_fetch_unit;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 2;
  localparam int STEP  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] pc;
  logic          w_enable;
  logic [AW-1:0] inc;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data = '0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_offset = '0;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [1:0]    dbg_state;
`ifdef FETCH_STATS_EN
  logic [15:0]   fetch_cnt;
  logic [15:0]   flush_cnt;
`endif

  fetch_unit #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STEP(STEP)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .w_enable   (w_enable),
    .inc        (inc),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
`ifdef FETCH_STATS_EN
    .fetch_cnt  (fetch_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- environment: program counter and imem ----------------
  logic [AW-1:0] pc_m = '0;
  logic [AW-1:0] pc_reset_val = '0;
  assign pc = pc_m;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    if (rst) pc_m <= pc_reset_val;
    else if (w_enable) pc_m <= pc_m + inc;
    if (imem_rd) imem_data <= mem_word(imem_addr);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int delivered = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] nxt_fetch = '0;
  logic          hold = 1'b0;
  logic [DW-1:0] h_inst = '0;
  logic [AW-1:0] h_pc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: fetch addresses advance by STEP from the reset/redirect target;
  // every issued address is delivered in order unless a redirect or reset intervenes.
  task automatic monitor();
    logic [AW-1:0] e;
    if (rst) begin
      exp_q.delete();
      nxt_fetch = pc_reset_val;
      hold = 1'b0;
      return;
    end
    check("addr_eq_pc", 32'(imem_addr), 32'(pc_m));
    if (hold) begin
      check("inst_stable", 32'(inst), 32'(h_inst));
      check("inst_pc_stable", 32'(inst_pc), 32'(h_pc));
    end
    if (br_taken) begin
      check("br_wen", 32'(w_enable), 32'd1);
      check("br_inc", 32'(inc), 32'(br_offset));
      check("br_rd", 32'(imem_rd), 32'd0);
      exp_q.delete();
      nxt_fetch = pc_m + br_offset;
    end else begin
      if (inst_valid && inst_ready) begin
        check("deliver_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_inst_pc", 32'(inst_pc), 32'(e));
          check("sb_inst", 32'(inst), 32'(mem_word(e)));
          delivered++;
        end
      end
      if (imem_rd) begin
        check("rd_wen", 32'(w_enable), 32'd1);
        check("rd_inc", 32'(inc), 32'(STEP));
        check("fetch_addr", 32'(imem_addr), 32'(nxt_fetch));
        exp_q.push_back(nxt_fetch);
        nxt_fetch = nxt_fetch + AW'(STEP);
        check("occupancy", 32'(exp_q.size() <= DEPTH), 32'd1);
      end else begin
        check("idle_wen", 32'(w_enable), 32'd0);
        check("idle_inc", 32'(inc), 32'd0);
      end
    end
    hold   = inst_valid && !inst_ready && !br_taken;
    h_inst = inst;
    h_pc   = inst_pc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic rdy, input logic br, input logic [AW-1:0] off);
    @(negedge clk);
    rst        = r;
    inst_ready = rdy;
    br_taken   = br;
    br_offset  = off;
    #1;
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
  endtask

  task automatic run(input logic rdy);
    drive(1'b0, rdy, 1'b0, '0);
    adv();
  endtask

  task automatic do_reset(input logic [AW-1:0] start);
    pc_reset_val = start;
    repeat (2) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      adv();
    end
  endtask

  logic          g_rst;
  logic          g_rdy;
  logic          g_br;
  logic [AW-1:0] g_off;
  int            since;

  initial begin
    // Streaming from reset: first fetch one cycle after release, first delivery two later.
    do_reset('0);
    drive(1'b0, 1'b1, 1'b0, '0);
    check("rst_wen", 32'(w_enable), 32'd0);
    check("rst_inc", 32'(inc), 32'd0);
    check("rst_rd", 32'(imem_rd), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("r1_rd", 32'(imem_rd), 32'd1);
    check("r1_inc", 32'(inc), 32'd2);
    check("r1_valid", 32'(inst_valid), 32'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("r2_valid", 32'(inst_valid), 32'd0);
    adv();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      check("seq_valid", 32'(inst_valid), 32'd1);
      check("seq_pc", 32'(inst_pc), 32'(2 * i));
      adv();
    end

    // Decode stalled: two fetches fill the queue, then fetch stops.
    do_reset('0);
    run(1'b0);
    run(1'b0);
    run(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      check("stall_wen", 32'(w_enable), 32'd0);
      check("stall_rd", 32'(imem_rd), 32'd0);
      check("stall_head_pc", 32'(inst_pc), 32'd0);
      check("stall_head_inst", 32'(inst), 32'(mem_word(16'h0000)));
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      check("release_valid", 32'(inst_valid), 32'd1);
      check("release_pc", 32'(inst_pc), 32'(2 * i));
      adv();
    end

    // Single redirect at PC 8 with offset 0x10.
    do_reset('0);
    repeat (5) run(1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h0010);
    check("brc_pc", 32'(pc_m), 32'h8);
    check("brc_inc", 32'(inc), 32'h10);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brc_flushed", 32'(inst_valid), 32'd0);
    check("brc_bubble", 32'(w_enable), 32'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brc_fetch_rd", 32'(imem_rd), 32'd1);
    check("brc_fetch_addr", 32'(imem_addr), 32'h18);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brc_n3_valid", 32'(inst_valid), 32'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brc_n4_valid", 32'(inst_valid), 32'd1);
    check("brc_n4_pc", 32'(inst_pc), 32'h18);
    adv();
    repeat (4) run(1'b1);

    // Back-to-back redirects: second lands during the bubble.
    do_reset('0);
    repeat (4) run(1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h0100);
    check("brd_pc1", 32'(pc_m), 32'h6);
    adv();
    drive(1'b0, 1'b1, 1'b1, 16'h0020);
    check("brd_wen2", 32'(w_enable), 32'd1);
    check("brd_inc2", 32'(inc), 32'h20);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brd_bubble", 32'(w_enable), 32'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brd_fetch_addr", 32'(imem_addr), 32'h126);
    adv();
    run(1'b1);
    drive(1'b0, 1'b1, 1'b0, '0);
    check("brd_first_pc", 32'(inst_pc), 32'h126);
    adv();
    repeat (4) run(1'b1);

    // PC wrap-around.
    do_reset(16'hFFFE);
    run(1'b1);
    drive(1'b0, 1'b1, 1'b0, '0);
    check("wrap_addr0", 32'(imem_addr), 32'hFFFE);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("wrap_addr1", 32'(imem_addr), 32'h0000);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("wrap_pc0", 32'(inst_pc), 32'hFFFE);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("wrap_pc1", 32'(inst_pc), 32'h0000);
    adv();

    // Reset with one entry queued and one response in flight.
    do_reset('0);
    repeat (3) run(1'b0);
    drive(1'b1, 1'b0, 1'b0, '0);
    adv();
    drive(1'b0, 1'b1, 1'b0, '0);
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst", 32'(inst), 32'd0);
    check("mid_rst_inst_pc", 32'(inst_pc), 32'd0);
    check("mid_rst_wen", 32'(w_enable), 32'd0);
    check("mid_rst_inc", 32'(inc), 32'd0);
    check("mid_rst_rd", 32'(imem_rd), 32'd0);
`ifdef FETCH_STATS_EN
    check("mid_rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("mid_rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    adv();
    repeat (6) run(1'b1);

    // Random traffic: back-pressure, redirects (including during the bubble), occasional reset.
    do_reset(AW'($urandom_range(0, 65535)));
    delivered = 0;
    since = 0;
    for (int i = 0; i < 3000; i++) begin
      g_rst = ($urandom_range(0, 299) == 0);
      g_rdy = ($urandom_range(0, 3) != 0);
      g_br  = !g_rst && (since >= 1) && ($urandom_range(0, 15) == 0);
      g_off = AW'($urandom);
      drive(g_rst, g_rdy, g_br, g_off);
      adv();
      since = g_rst ? 0 : since + 1;
    end
    check("random_progress", 32'(delivered > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
